// File: rtl/cond_logic_pkg.sv
// Shared condition-code definitions: enum, flag bit positions, FlagW bit roles.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cond_logic_pkg;

    // Instruction condition field encodings, Instr[31:28]
    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

    // FlagW bits: upper half writes N,Z; lower half writes C,V
    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Evaluates an instruction condition field against the stored flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module cond_check
    import cond_logic_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v;

    assign n = Flags[N_IDX];
    assign z = Flags[Z_IDX];
    assign c = Flags[C_IDX];
    assign v = Flags[V_IDX];

    // Decode the condition field; the reserved NV encoding never passes
    always_comb begin
        CondEx = 1'b0;
        case (cond_e'(Cond))
            EQ:      CondEx = z;
            NE:      CondEx = ~z;
            CS:      CondEx = c;
            CC:      CondEx = ~c;
            MI:      CondEx = n;
            PL:      CondEx = ~n;
            VS:      CondEx = v;
            VC:      CondEx = ~v;
            HI:      CondEx = c & ~z;
            LS:      CondEx = ~c | z;
            GE:      CondEx = (n == v);
            LT:      CondEx = (n != v);
            GT:      CondEx = ~z & (n == v);
            LE:      CondEx = z | (n != v);
            AL:      CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Condition unit: gates decoder write requests by the condition and holds the NZCV flags.
// Latency: write enables and CondEx are combinational; Flags/CondExR update on the next edge.
// Backpressure: Stall suppresses every update and freezes Flags and CondExR.
module cond_logic
    import cond_logic_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       Stall,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] Flags,
    output logic       CondEx,
    output logic       CondExR
);

    logic [3:0] flags_q, flags_d;
    logic       condexr_q, condexr_d;
    logic       cond_ex;
    logic       commit;

    // Condition is judged against stored flags only, so a flag load is seen one cycle later
    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (flags_q),
        .CondEx (cond_ex)
    );

    // An instruction commits only when its condition passes and the pipeline is not held
    assign commit   = cond_ex & ~Stall;

    assign PCSrc    = PCS  & commit;
    assign RegWrite = RegW & commit;
    assign MemWrite = MemW & commit;

    // Next-state for the two independently writable flag halves and the registered CondEx
    always_comb begin
        flags_d   = flags_q;
        condexr_d = condexr_q;
        if (FlagW[FW_NZ] && commit) begin
            flags_d[N_IDX:Z_IDX] = ALUFlags[N_IDX:Z_IDX];
        end
        if (FlagW[FW_CV] && commit) begin
            flags_d[C_IDX:V_IDX] = ALUFlags[C_IDX:V_IDX];
        end
        if (!Stall) begin
            condexr_d = cond_ex;
        end
    end

    // State registers; reset overrides any pending flag write or stall
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q   <= 4'b0000;
            condexr_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            condexr_q <= condexr_d;
        end
    end

    assign Flags   = flags_q;
    assign CondEx  = cond_ex;
    assign CondExR = condexr_q;

endmodule

// File: tb/tb_cond_logic.sv
// Directed bench for cond_logic: reset, gating, split flag writes, stall, full cond sweep.
// Latency: checks combinational outputs 1 time unit after inputs change, state 1 unit after the edge.
// Backpressure: exercises Stall holding all state.
module tb_cond_logic;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       Stall;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic [3:0] Flags;
    logic       CondEx;
    logic       CondExR;

    int tests_run;
    int tests_failed;

    cond_logic dut (
        .clk      (clk),
        .reset    (reset),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .RegW     (RegW),
        .MemW     (MemW),
        .Stall    (Stall),
        .PCSrc    (PCSrc),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .Flags    (Flags),
        .CondEx   (CondEx),
        .CondExR  (CondExR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference condition table written straight from the ISA condition list
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cf;
            4'd3:  return !cf;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cf && !z;
            4'd9:  return !cf || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset    = 1'b1;
        Cond     = 4'b0000;
        ALUFlags = 4'b0000;
        FlagW    = 2'b00;
        PCS      = 1'b0;
        RegW     = 1'b0;
        MemW     = 1'b0;
        Stall    = 1'b0;

        // Reset state, and write gating still active while reset is held
        tick();
        tick();
        check("rst_flags", {28'd0, Flags}, 32'h0);
        check("rst_condexr", {31'd0, CondExR}, 32'h0);
        Cond = 4'b1110; RegW = 1'b1;
        #1;
        check("rst_regwrite", {31'd0, RegWrite}, 32'h1);
        check("rst_memwrite", {31'd0, MemWrite}, 32'h0);
        check("rst_pcsrc", {31'd0, PCSrc}, 32'h0);
        reset = 1'b0;
        tick();
        check("post_rst_flags", {28'd0, Flags}, 32'h0);

        // Load Z via AL, then branch on EQ / NE
        RegW = 1'b0; FlagW = 2'b11; ALUFlags = 4'b0100;
        #1;
        tick();
        check("load_z_flags", {28'd0, Flags}, 32'h4);
        FlagW = 2'b00; Cond = 4'b0000; PCS = 1'b1;
        #1;
        check("eq_pcsrc", {31'd0, PCSrc}, 32'h1);
        Cond = 4'b0001;
        #1;
        check("ne_pcsrc", {31'd0, PCSrc}, 32'h0);

        // Failed condition blocks both flag halves and the register write
        PCS = 1'b0; FlagW = 2'b11; ALUFlags = 4'b1011; RegW = 1'b1;
        #1;
        check("fail_regwrite", {31'd0, RegWrite}, 32'h0);
        tick();
        check("fail_flags_held", {28'd0, Flags}, 32'h4);

        // Clear flags, then write only C,V
        RegW = 1'b0; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0000;
        tick();
        check("clear_flags", {28'd0, Flags}, 32'h0);
        FlagW = 2'b01; ALUFlags = 4'b1111;
        tick();
        check("cv_only_flags", {28'd0, Flags}, 32'h3);
        FlagW = 2'b00; Cond = 4'b1010;
        #1;
        check("ge_condex", {31'd0, CondEx}, 32'h0);
        Cond = 4'b1100;
        #1;
        check("gt_condex", {31'd0, CondEx}, 32'h0);
        Cond = 4'b1011;
        #1;
        check("lt_condex", {31'd0, CondEx}, 32'h1);

        // Prime CondExR to 0 with the never-condition
        Cond = 4'b1111;
        tick();
        check("condexr_nv", {31'd0, CondExR}, 32'h0);

        // Stall wins over every write request
        Stall = 1'b1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1111;
        MemW = 1'b1; RegW = 1'b1; PCS = 1'b1;
        #1;
        check("stall_memwrite", {31'd0, MemWrite}, 32'h0);
        check("stall_regwrite", {31'd0, RegWrite}, 32'h0);
        check("stall_pcsrc", {31'd0, PCSrc}, 32'h0);
        check("stall_condex", {31'd0, CondEx}, 32'h1);
        tick();
        check("stall_flags", {28'd0, Flags}, 32'h3);
        check("stall_condexr", {31'd0, CondExR}, 32'h0);
        Stall = 1'b0;
        #1;
        check("unstall_memwrite", {31'd0, MemWrite}, 32'h1);
        tick();
        check("unstall_flags", {28'd0, Flags}, 32'hF);
        check("unstall_condexr", {31'd0, CondExR}, 32'h1);

        // N,Z-only write
        MemW = 1'b0; RegW = 1'b0; PCS = 1'b0;
        FlagW = 2'b10; ALUFlags = 4'b0000;
        tick();
        check("nz_only_flags", {28'd0, Flags}, 32'h3);

        // Reset beats a concurrent flag write and stall
        FlagW = 2'b11; ALUFlags = 4'b1111;
        tick();
        check("pre_rst_flags", {28'd0, Flags}, 32'hF);
        reset = 1'b1; Stall = 1'b1;
        tick();
        check("rst_win_flags", {28'd0, Flags}, 32'h0);
        check("rst_win_condexr", {31'd0, CondExR}, 32'h0);
        reset = 1'b0; Stall = 1'b0;

        // Sweep all conditions against all flag values
        for (int f = 0; f < 16; f++) begin
            Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'(f);
            tick();
            check($sformatf("sweep_load_f%0d", f), {28'd0, Flags}, 32'(f));
            FlagW = 2'b00;
            for (int c = 0; c < 16; c++) begin
                Cond = 4'(c);
                #1;
                check($sformatf("sweep_c%0d_f%0d", c, f), {31'd0, CondEx},
                      {31'd0, ref_cond(4'(c), 4'(f))});
                check($sformatf("idle_wr_c%0d_f%0d", c, f),
                      {29'd0, PCSrc, RegWrite, MemWrite}, 32'h0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
